// File: rtl/cp0_tlb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cp0_tlb_ctrl : CP0 MMU registers and TLBP/TLBR/TLBWI/TLBWR sequencer | rev 1.0
// ---------------------------------------------------------------------------
module cp0_tlb_ctrl #(
   parameter int TLB_ENTRIES = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   output logic        op_ready,
   output logic        op_done,
   input  logic        c0_we,
   input  logic [4:0]  c0_addr,
   input  logic [31:0] c0_wdata,
   output logic [31:0] c0_rdata,
   input  logic        tlb_ex_valid,
   input  logic [31:0] tlb_ex_vaddr,
   output logic [31:0] cp0_index,
   output logic [31:0] cp0_entryhi,
   output logic [31:0] cp0_pagemask,
   output logic [31:0] cp0_entrylo0,
   output logic [31:0] cp0_entrylo1,
   output logic [31:0] cp0_random,
   output logic        tlbwi,
   output logic        tlbwr,
   input  logic [31:0] tlbp_index,
   input  logic [89:0] tlbr_tlb
);
   localparam int IW = $clog2(TLB_ENTRIES);
   localparam logic [IW-1:0] RAND_TOP = IW'(TLB_ENTRIES - 1);
   localparam logic [1:0] OP_TLBP  = 2'd0;
   localparam logic [1:0] OP_TLBR  = 2'd1;
   localparam logic [1:0] OP_TLBWI = 2'd2;
   localparam logic [1:0] OP_TLBWR = 2'd3;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
   state_t state, state_next;
   logic [1:0] op_lat;

   logic          index_p;
   logic [IW-1:0] index_r, random_r, wired_r;
   logic [25:0]   entrylo0_r, entrylo1_r;
   logic [8:0]    ctx_base;
   logic [18:0]   ctx_vpn2;
   logic [11:0]   pagemask_r;
   logic [31:0]   badvaddr_r;
   logic [18:0]   hi_vpn2;
   logic [7:0]    hi_asid;

   logic idle, accept, exec_ok, mtc0, probe_unused;

   assign idle         = (state == IDLE);
   assign accept       = idle && op_valid && !tlb_ex_valid;
   assign exec_ok      = (state == EXEC) && !tlb_ex_valid;
   assign mtc0         = idle && c0_we;
   assign probe_unused = ^tlbp_index[30:IW];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // An exception in IDLE also blocks acceptance: the op is simply not taken.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (op_valid) state_next = EXEC;
         EXEC:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (tlb_ex_valid) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     op_lat <= OP_TLBP;
      else if (accept) op_lat <= op_code;
   end

   assign op_ready = idle;
   assign op_done  = (state == DONE) && !tlb_ex_valid;
   assign tlbwi    = exec_ok && (op_lat == OP_TLBWI);
   assign tlbwr    = exec_ok && (op_lat == OP_TLBWR);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index_p    <= 1'b0;
         index_r    <= '0;
         wired_r    <= '0;
         entrylo0_r <= '0;
         entrylo1_r <= '0;
         ctx_base   <= '0;
         ctx_vpn2   <= '0;
         pagemask_r <= '0;
         badvaddr_r <= '0;
         hi_vpn2    <= '0;
         hi_asid    <= '0;
      end else begin
         if (mtc0) begin
            case (c0_addr)
               5'd0: index_r    <= c0_wdata[IW-1:0];
               5'd2: entrylo0_r <= c0_wdata[25:0];
               5'd3: entrylo1_r <= c0_wdata[25:0];
               5'd4: if (!tlb_ex_valid) ctx_base <= c0_wdata[31:23];
               5'd5: pagemask_r <= c0_wdata[24:13];
               5'd6: wired_r    <= c0_wdata[IW-1:0];
               5'd10: if (!tlb_ex_valid) begin
                  hi_vpn2 <= c0_wdata[31:13];
                  hi_asid <= c0_wdata[7:0];
               end
               default: ;
            endcase
         end
         if (exec_ok && op_lat == OP_TLBP) begin
            index_p <= tlbp_index[31];
            index_r <= tlbp_index[IW-1:0];
         end
         // Both EntryLo G bits come from the single global bit of the entry.
         if (exec_ok && op_lat == OP_TLBR) begin
            hi_vpn2    <= tlbr_tlb[89:71];
            hi_asid    <= tlbr_tlb[70:63];
            pagemask_r <= tlbr_tlb[62:51];
            entrylo0_r <= {tlbr_tlb[49:25], tlbr_tlb[50]};
            entrylo1_r <= {tlbr_tlb[24:0], tlbr_tlb[50]};
         end
         if (tlb_ex_valid) begin
            badvaddr_r <= tlb_ex_vaddr;
            hi_vpn2    <= tlb_ex_vaddr[31:13];
            ctx_vpn2   <= tlb_ex_vaddr[31:13];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                      random_r <= RAND_TOP;
      else if (mtc0 && c0_addr == 5'd6) random_r <= RAND_TOP;
      else if (random_r == wired_r)     random_r <= RAND_TOP;
      else                              random_r <= random_r - 1'b1;
   end

   assign cp0_index    = {index_p, {(31-IW){1'b0}}, index_r};
   assign cp0_entryhi  = {hi_vpn2, 5'd0, hi_asid};
   assign cp0_pagemask = {7'd0, pagemask_r, 13'd0};
   assign cp0_entrylo0 = {6'd0, entrylo0_r};
   assign cp0_entrylo1 = {6'd0, entrylo1_r};
   assign cp0_random   = {{(32-IW){1'b0}}, random_r};

   always_comb begin
      c0_rdata = 32'd0;
      case (c0_addr)
         5'd0:    c0_rdata = cp0_index;
         5'd1:    c0_rdata = cp0_random;
         5'd2:    c0_rdata = cp0_entrylo0;
         5'd3:    c0_rdata = cp0_entrylo1;
         5'd4:    c0_rdata = {ctx_base, ctx_vpn2, 4'd0};
         5'd5:    c0_rdata = cp0_pagemask;
         5'd6:    c0_rdata = {{(32-IW){1'b0}}, wired_r};
         5'd8:    c0_rdata = badvaddr_r;
         5'd10:   c0_rdata = cp0_entryhi;
         default: c0_rdata = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cp0_tlb_ctrl.sv
`default_nettype none
// tb_cp0_tlb_ctrl : scoreboard bench checking cp0_tlb_ctrl against a field-level CP0 model.
module tb_cp0_tlb_ctrl;
   logic        clk;
   logic        resetn, op_valid, op_ready, op_done, c0_we, tlb_ex_valid, tlbwi, tlbwr;
   logic [1:0]  op_code;
   logic [4:0]  c0_addr;
   logic [31:0] c0_wdata, c0_rdata, tlb_ex_vaddr, tlbp_index;
   logic [31:0] cp0_index, cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_random;
   logic [89:0] tlbr_tlb;

   cp0_tlb_ctrl #(.TLB_ENTRIES(32)) dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
      .op_ready(op_ready), .op_done(op_done), .c0_we(c0_we), .c0_addr(c0_addr),
      .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .tlb_ex_valid(tlb_ex_valid),
      .tlb_ex_vaddr(tlb_ex_vaddr), .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
      .cp0_pagemask(cp0_pagemask), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
      .cp0_random(cp0_random), .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp_index(tlbp_index),
      .tlbr_tlb(tlbr_tlb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [4:0] addr; logic [31:0] data; logic [31:0] rnd; logic rdy; } rd_t;
   typedef struct { int cyc; logic kind; logic [31:0] idx, hi, pm, lo0, lo1; } wr_t;
   rd_t rdq[$];
   wr_t wq[$];
   int  dq[$];
   logic rd_chk;

   // Reference model: architectural fields kept as plain integers.
   logic [31:0] m_p, m_idx, m_rand, m_lo0, m_lo1, m_cbase, m_cvpn, m_pm, m_wired, m_badv, m_hvpn, m_asid;
   int          m_phase;   // 0 idle, 1 executing, 2 completing
   logic [1:0]  m_op;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_p = 0; m_idx = 0; m_rand = 31; m_lo0 = 0; m_lo1 = 0; m_cbase = 0; m_cvpn = 0;
      m_pm = 0; m_wired = 0; m_badv = 0; m_hvpn = 0; m_asid = 0; m_phase = 0; m_op = 0;
   endtask

   function automatic logic [31:0] mread(input logic [4:0] a);
      case (a)
         5'd0:    return (m_p << 31) | m_idx;
         5'd1:    return m_rand;
         5'd2:    return m_lo0;
         5'd3:    return m_lo1;
         5'd4:    return (m_cbase << 23) | (m_cvpn << 4);
         5'd5:    return m_pm << 13;
         5'd6:    return m_wired;
         5'd8:    return m_badv;
         5'd10:   return (m_hvpn << 13) | m_asid;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      logic ex, wr, acc;
      logic [89:0] t;
      if (!resetn) begin
         model_reset();
         return;
      end
      ex  = tlb_ex_valid;
      wr  = c0_we && (m_phase == 0);
      acc = (m_phase == 0) && op_valid && !ex;
      if (wr && c0_addr == 5'd6)  m_rand = 31;
      else if (m_rand == m_wired) m_rand = 31;
      else                        m_rand = m_rand - 1;
      if (wr) begin
         case (c0_addr)
            5'd0: m_idx = c0_wdata % 32;
            5'd2: m_lo0 = c0_wdata % (1 << 26);
            5'd3: m_lo1 = c0_wdata % (1 << 26);
            5'd4: if (!ex) m_cbase = c0_wdata >> 23;
            5'd5: m_pm = (c0_wdata >> 13) % 4096;
            5'd6: m_wired = c0_wdata % 32;
            5'd10: if (!ex) begin m_hvpn = c0_wdata >> 13; m_asid = c0_wdata % 256; end
            default: ;
         endcase
      end
      if (m_phase == 1 && !ex) begin
         if (m_op == 2'd0) begin
            m_p   = tlbp_index >> 31;
            m_idx = tlbp_index % 32;
         end else if (m_op == 2'd1) begin
            t      = tlbr_tlb;
            m_hvpn = 32'(t >> 71);
            m_asid = 32'((t >> 63) % 256);
            m_pm   = 32'((t >> 51) % 4096);
            m_lo0  = 32'((t >> 25) % (1 << 25)) * 2 + 32'(t[50]);
            m_lo1  = 32'(t % (1 << 25)) * 2 + 32'(t[50]);
         end
      end
      if (ex) begin
         m_badv = tlb_ex_vaddr;
         m_hvpn = tlb_ex_vaddr >> 13;
         m_cvpn = tlb_ex_vaddr >> 13;
      end
      if (acc) m_op = op_code;
      if (ex)                m_phase = 0;
      else if (m_phase == 0) m_phase = acc ? 1 : 0;
      else if (m_phase == 1) m_phase = 2;
      else                   m_phase = 0;
   endtask

   task automatic cycle();
      wr_t w;
      if (resetn && !tlb_ex_valid && m_phase == 1 && m_op[1]) begin
         w.cyc = cyc; w.kind = m_op[0];
         w.idx = mread(0); w.hi = mread(10); w.pm = mread(5); w.lo0 = mread(2); w.lo1 = mread(3);
         wq.push_back(w);
      end
      if (resetn && !tlb_ex_valid && m_phase == 2) dq.push_back(cyc);
      model_edge();
      @(posedge clk);
      #1;
      op_valid = 0; c0_we = 0; tlb_ex_valid = 0; rd_chk = 0;
   endtask

   task automatic set_rd(input logic [4:0] a);
      rd_t r;
      r.addr = a; r.data = mread(a); r.rnd = m_rand; r.rdy = (m_phase == 0);
      c0_addr = a;
      rd_chk  = 1;
      rdq.push_back(r);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      c0_we = 1; c0_addr = a; c0_wdata = d;
      cycle();
   endtask

   task automatic do_op(input logic [1:0] c);
      op_valid = 1; op_code = c;
      cycle(); cycle(); cycle();
   endtask

   rd_t mon_r;
   wr_t mon_w;
   int  mon_d;
   always @(negedge clk) begin
      if (resetn) begin
         if (rd_chk && rdq.size() != 0) begin
            mon_r = rdq.pop_front();
            chk($sformatf("rdata[%0d]", mon_r.addr), c0_rdata, mon_r.data);
            chk("cp0_random", cp0_random, mon_r.rnd);
            chk("op_ready", {31'd0, op_ready}, {31'd0, mon_r.rdy});
         end
         if (tlbwi || tlbwr) begin
            if (wq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_strobe: got tlbwi=%b tlbwr=%b want none (cycle %0d)", tlbwi, tlbwr, cyc);
            end else begin
               mon_w = wq.pop_front();
               chk("strobe_kind", {30'd0, tlbwi, tlbwr}, mon_w.kind ? 32'd1 : 32'd2);
               chk("strobe_cycle", cyc, mon_w.cyc);
               chk("wr_index", cp0_index, mon_w.idx);
               chk("wr_entryhi", cp0_entryhi, mon_w.hi);
               chk("wr_pagemask", cp0_pagemask, mon_w.pm);
               chk("wr_entrylo0", cp0_entrylo0, mon_w.lo0);
               chk("wr_entrylo1", cp0_entrylo1, mon_w.lo1);
            end
         end
         if (op_done) begin
            if (dq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: got op_done=1 want 0 (cycle %0d)", cyc);
            end else begin
               mon_d = dq.pop_front();
               chk("done_cycle", cyc, mon_d);
            end
         end
      end
   end

   initial begin
      logic [95:0] rv;
      resetn = 0; op_valid = 0; op_code = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
      tlb_ex_valid = 0; tlb_ex_vaddr = 0; tlbp_index = 0; tlbr_tlb = '0; rd_chk = 0;
      model_reset();
      repeat (3) cycle();
      resetn = 1;

      // Random free-runs 31..0 then wraps with Wired = 0.
      for (int i = 0; i < 34; i++) begin set_rd(5'd1); cycle(); end
      for (int a = 0; a < 16; a++) begin set_rd(5'(a)); cycle(); end

      mtc0(5'd6, 32'd8);
      for (int i = 0; i < 30; i++) begin set_rd(5'd1); cycle(); end
      mtc0(5'd6, 32'd31);
      for (int i = 0; i < 3; i++) begin set_rd(5'd1); cycle(); end
      mtc0(5'd6, 32'd0);

      mtc0(5'd0, 32'd5);
      mtc0(5'd10, 32'h0040_2003);
      mtc0(5'd2, 32'h0000_1047);
      do_op(2'd2);
      set_rd(5'd0); cycle();

      tlbp_index = 32'h8000_0000; do_op(2'd0); set_rd(5'd0); cycle();
      tlbp_index = 32'h0000_0007; do_op(2'd0); set_rd(5'd0); cycle();

      tlbr_tlb = {19'h00201, 8'h03, 12'h000, 1'b1, 25'h0000417, 25'h0000437};
      do_op(2'd1);
      set_rd(5'd10); cycle(); set_rd(5'd5); cycle(); set_rd(5'd2); cycle(); set_rd(5'd3); cycle();

      // MTC0 while busy is dropped; MTC0 on the accept cycle is seen by the op.
      op_valid = 1; op_code = 2'd3; cycle();
      c0_we = 1; c0_addr = 5'd0; c0_wdata = 32'h1F; cycle();
      cycle(); set_rd(5'd0); cycle();
      op_valid = 1; op_code = 2'd2; c0_we = 1; c0_addr = 5'd0; c0_wdata = 32'd9;
      cycle(); cycle(); cycle();

      // Exception aborts a TLBWR in flight.
      mtc0(5'd4, 32'hFF80_0000);
      op_valid = 1; op_code = 2'd3; cycle();
      tlb_ex_valid = 1; tlb_ex_vaddr = 32'h1234_5678; cycle();
      set_rd(5'd8); cycle(); set_rd(5'd10); cycle(); set_rd(5'd4); cycle();

      // Exception beats a simultaneous EntryHi write.
      c0_we = 1; c0_addr = 5'd10; c0_wdata = 32'hFFFF_E0FF;
      tlb_ex_valid = 1; tlb_ex_vaddr = 32'hABCD_E000; cycle();
      set_rd(5'd10); cycle();

      // Reset during EXEC: no strobe, no done, registers back to reset values.
      op_valid = 1; op_code = 2'd2; cycle();
      resetn = 0; model_reset(); cycle(); cycle();
      resetn = 1;
      set_rd(5'd1); cycle(); set_rd(5'd10); cycle(); set_rd(5'd0); cycle();

      for (int i = 0; i < 800; i++) begin
         rv = {$urandom(), $urandom(), $urandom()};
         tlbr_tlb   = rv[89:0];
         tlbp_index = $urandom();
         if ($urandom_range(0, 3) == 0) begin
            c0_we = 1; c0_addr = 5'($urandom_range(0, 15)); c0_wdata = $urandom();
         end else begin
            set_rd(5'($urandom_range(0, 15)));
         end
         if ($urandom_range(0, 2) == 0) begin op_valid = 1; op_code = 2'($urandom_range(0, 3)); end
         if (!(m_phase == 0 && op_valid) && $urandom_range(0, 19) == 0) begin
            tlb_ex_valid = 1; tlb_ex_vaddr = $urandom();
         end
         cycle();
      end
      for (int a = 0; a < 11; a++) begin set_rd(5'(a)); cycle(); end
      repeat (3) cycle();
      chk("pending_strobes", 32'(wq.size()), 32'd0);
      chk("pending_dones", 32'(dq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cp0_tlb_ctrl.md
Name: cp0_tlb_ctrl

Overview:
CP0-side controller that owns the MMU registers (Index, Random, EntryLo0/1, Context, PageMask, Wired, BadVAddr, EntryHi) and drives the TLB array's register-facing interface.
- Sequences TLBP/TLBR/TLBWI/TLBWR through a small FSM with a valid/ready/done handshake to the pipeline.
- Captures probe and read results back from the TLB.
- Updates BadVAddr, EntryHi and Context on TLB exceptions.

Parameters:
- TLB_ENTRIES, 32, number of TLB entries. Index, Random and Wired are log2 = 5 bits wide.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  TLB instruction request
- op_code  in  2  0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
- op_ready  out  1  controller idle, can accept
- op_done  out  1  one-cycle completion pulse
- c0_we  in  1  MTC0 write strobe
- c0_addr  in  5  CP0 register number
- c0_wdata  in  32  MTC0 data
- c0_rdata  out  32  MFC0 data (combinational)
- tlb_ex_valid  in  1  TLB refill/invalid/modified exception commit
- tlb_ex_vaddr  in  32  faulting virtual address
- cp0_index, cp0_entryhi, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_random  out  32 each  register values to TLB
- tlbwi, tlbwr  out  1 each  TLB write strobes
- tlbp_index  in  32  probe result: bit31 = miss, [4:0] = hit index
- tlbr_tlb  in  90  entry at cp0_index[4:0]

Behaviour:
- Register map (c0_addr), with writable fields:
  - 0 Index: [4:0] writable; [31] P, read-only.
  - 1 Random: read-only.
  - 2 EntryLo0, 3 EntryLo1: [25:0] writable.
  - 4 Context: [31:23] PTEBase writable; [22:4] BadVPN2 read-only.
  - 5 PageMask: [24:13] writable.
  - 6 Wired: [4:0] writable.
  - 8 BadVAddr: read-only.
  - 10 EntryHi: [31:13] and [7:0] writable.
  - All other addresses read 0 and ignore writes. Non-writable bits read 0.
- Reset: all registers 0 except Random=31. op_ready=1, op_done=0, tlbwi=tlbwr=0, FSM in IDLE.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: op_ready=1. When op_valid=1, latch op_code and go to EXEC.
  - EXEC (1 cycle), by latched op:
    - TLBP: at the end of the cycle, Index <= {tlbp_index[31], 26'd0, tlbp_index[4:0]}.
    - TLBR: at the end of the cycle, load the 90-bit entry:
      - EntryHi[31:13] <= [89:71]; EntryHi[7:0] <= [70:63].
      - PageMask[24:13] <= [62:51].
      - EntryLo0[25:1] <= [49:25]; EntryLo1[25:1] <= [24:0].
      - EntryLo0[0] <= [50]; EntryLo1[0] <= [50].
    - TLBWI: tlbwi=1 for exactly this cycle.
    - TLBWR: tlbwr=1 for exactly this cycle.
  - DONE: op_done=1 for one cycle, then IDLE.
  - Timing: acceptance edge is T; op_done is high in cycle T+2; op_ready is high again in T+3.
- Random:
  - Every cycle: if Random == Wired then Random <= 31, else Random <= Random-1.
  - An MTC0 to Wired forces Random <= 31 in the same edge, overriding the decrement.
  - Wired == 31 holds Random at 31.
- MTC0 while FSM is not IDLE is dropped; registers are unchanged.
- MTC0 in IDLE in the same cycle an op is accepted is applied, and the op sees the new value in EXEC.
- TLB exception (tlb_ex_valid=1), highest priority:
  - BadVAddr <= vaddr; EntryHi[31:13] <= vaddr[31:13]; Context[22:4] <= vaddr[31:13].
  - EntryHi ASID is unchanged.
  - Aborts any in-flight op: FSM -> IDLE, tlbwi/tlbwr forced 0 that cycle, no op_done.
  - A simultaneous MTC0 to EntryHi, Context or BadVAddr loses to the exception.
- Reset asserted mid-operation: immediate return to reset state; no strobe or done is emitted.
- cp0_* outputs are the register values directly. cp0_random = {27'd0, Random}.

Test Plan:
- Reset, then read c0_addr 1 -> 31 on the first read; value decrements by 1 per cycle, reaching 0 after 31 cycles, then 31 again.
- MTC0 Wired=8, observe Random -> 31 next cycle, then counts 31..8 and wraps to 31; never below 8.
- MTC0 Index=5, EntryHi=0x0040_2003, EntryLo0=0x0000_1047, issue TLBWI -> tlbwi high only in cycle T+1, op_done in T+2; cp0_index=5, cp0_entryhi=0x0040_2003, cp0_entrylo0=0x0000_1047 while tlbwi is high.
- TLBP with tlbp_index=0x8000_0000 -> Index reads 0x8000_0000. Repeat with tlbp_index=0x0000_0007 -> Index reads 0x0000_0007.
- TLBR with tlbr_tlb={19'h00201, 8'h03, 12'h000, 1'b1, 25'h0000417, 25'h0000437} -> EntryHi=0x0040_2003, PageMask=0, EntryLo0=0x0000_082F, EntryLo1=0x0000_086F.
- Issue TLBWR, assert tlb_ex_valid with vaddr=0x1234_5678 during EXEC -> no tlbwr and no op_done; BadVAddr=0x1234_5678, EntryHi[31:13]=0x091A2, Context[22:4]=0x091A2; op_ready=1 next cycle.
